// File: rtl/boardman_pkg.sv
// Shared types and constants for the board-manager WISHBONE initiator.
// Used by boardman_wb_master and its byte/word shifter bm_byte_word.
package boardman_pkg;

  // Command sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_HDR2,
    ST_WDAT,
    ST_WBCYC,
    ST_RDTX,
    ST_STAT
  } bm_state_e;

  // Operations on the 4-byte shift register.
  typedef enum logic [1:0] {
    BW_HOLD,
    BW_PUSH,
    BW_POP,
    BW_LOAD
  } bw_op_e;

  // Header layout: {W, B, U, addr[20:0]}.
  localparam int HDR_W_BIT = 23;
  localparam int HDR_B_BIT = 22;
  localparam int HDR_U_BIT = 21;

  // Write status byte values.
  localparam logic [7:0] STAT_OK  = 8'h00;
  localparam logic [7:0] STAT_ERR = 8'h01;

  // Word returned for a read that ended in err/rty/timeout.
  localparam logic [31:0] RD_ERR_WORD = 32'hFFFF_FFFF;

  // Number of WB words a command moves: 1, or 1/2/4/8 when the B bit is set.
  function automatic logic [3:0] burst_words(input logic burst, input logic [1:0] size);
    return burst ? (4'd1 << size) : 4'd1;
  endfunction

endpackage

// File: rtl/bm_byte_word.sv
// 4-byte MSB-first shift register with a 2-bit byte counter.
// Packs received bytes into a word (PUSH) or unpacks a loaded word into
// bytes (LOAD then POP). last_o flags the fourth byte of a word.
module bm_byte_word
  import boardman_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  bw_op_e      op_i,
  input  logic [7:0]  byte_i,
  input  logic [31:0] word_i,
  output logic [31:0] word_o,
  output logic [7:0]  byte_o,
  output logic        last_o
);

  logic [31:0] sr_q;
  logic [1:0]  cnt_q;

  // Shift one byte in or out, or parallel-load a word and restart the count.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // in the design sees the pre-edge values of all the others.
    if (!wb_rst_ni) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      unique case (op_i)
        BW_PUSH: begin
          sr_q  <= {sr_q[23:0], byte_i};
          cnt_q <= cnt_q + 2'd1;
        end
        BW_POP: begin
          sr_q  <= {sr_q[23:0], 8'h00};
          cnt_q <= cnt_q + 2'd1;
        end
        BW_LOAD: begin
          sr_q  <= word_i;
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign word_o = sr_q;
  assign byte_o = sr_q[31:24];
  assign last_o = (cnt_q == 2'd3);

endmodule

// File: rtl/boardman_wb_master.sv
// Byte-stream to WISHBONE initiator for the debug board manager.
// Decodes 3-byte headers {W, B, U, addr[20:0]}, runs single or burst
// classic 32-bit WB cycles and answers with read bytes or a status byte.
// Optional feature macro: BOARDMAN_WB_TIMEOUT_EN (bus timeout counter).
module boardman_wb_master
  import boardman_pkg::*;
#(
  parameter int ADDR_W         = 25,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [7:0]        rx_dat_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [7:0]        tx_dat_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [1:0]        burst_size_i,
  input  logic [3:0]        upper_addr_i,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  bm_state_e         state_q, state_d;
  bw_op_e            bw_op;
  logic [31:0]       bw_word, bw_ld_word;
  logic [7:0]        bw_byte;
  logic              bw_last;
  logic [23:0]       hdr;
  logic [ADDR_W-1:0] hdr_addr;
  logic              rx_fire, tx_fire;
  logic              cyc_q, is_write_q, any_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        words_left_q;
  logic              tmo, bus_err, word_done, word_err;

  // The first two header bytes sit in the shifter; the third is still on rx_dat_i.
  assign hdr      = {bw_word[15:0], rx_dat_i};
  assign hdr_addr = ADDR_W'({(hdr[HDR_U_BIT] ? upper_addr_i : 4'h0), hdr[20:0]})
                    & ~ADDR_W'(3);

  assign rx_ready_o = state_q inside {ST_IDLE, ST_HDR1, ST_HDR2, ST_WDAT};
  assign tx_valid_o = (state_q == ST_RDTX) || (state_q == ST_STAT);
  assign rx_fire    = rx_valid_i & rx_ready_o;
  assign tx_fire    = tx_valid_o & tx_ready_i;

  // Retry and timeout are folded into error; err beats a simultaneous ack.
  assign bus_err   = wb_err_i | wb_rty_i | tmo;
  assign word_done = cyc_q & (wb_ack_i | bus_err);
  assign word_err  = cyc_q & bus_err;

  // Read data is captured into the shifter on completion; a header clears it.
  assign bw_ld_word = (state_q == ST_WBCYC) ? (word_err ? RD_ERR_WORD : wb_dat_i) : 32'h0;

  bm_byte_word u_byte_word (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .op_i      (bw_op),
    .byte_i    (rx_dat_i),
    .word_i    (bw_ld_word),
    .word_o    (bw_word),
    .byte_o    (bw_byte),
    .last_o    (bw_last)
  );

`ifdef BOARDMAN_WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  // Count cycles with cyc high; restart whenever a new WB word begins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (state_q != ST_WBCYC) begin
      tmo_cnt_q <= '0;
    end else if (cyc_q) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  assign tmo = cyc_q && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state and shifter control.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    bw_op   = BW_HOLD;
    unique case (state_q)
      ST_IDLE: if (rx_fire) begin
        bw_op   = BW_PUSH;
        state_d = ST_HDR1;
      end
      ST_HDR1: if (rx_fire) begin
        bw_op   = BW_PUSH;
        state_d = ST_HDR2;
      end
      ST_HDR2: if (rx_fire) begin
        bw_op   = BW_LOAD;
        state_d = hdr[HDR_W_BIT] ? ST_WDAT : ST_WBCYC;
      end
      ST_WDAT: if (rx_fire) begin
        bw_op = BW_PUSH;
        if (bw_last) state_d = ST_WBCYC;
      end
      ST_WBCYC: if (word_done) begin
        if (is_write_q) begin
          state_d = (words_left_q == 4'd1) ? ST_STAT : ST_WDAT;
        end else begin
          bw_op   = BW_LOAD;
          state_d = ST_RDTX;
        end
      end
      ST_RDTX: if (tx_fire) begin
        bw_op = BW_POP;
        if (bw_last) state_d = (words_left_q == 4'd0) ? ST_IDLE : ST_WBCYC;
      end
      ST_STAT: if (tx_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // cyc/stb: raise one cycle after entering WBCYC, drop after the completing cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cyc_q <= 1'b0;
    end else if (state_q == ST_WBCYC && !cyc_q) begin
      cyc_q <= 1'b1;
    end else if (word_done) begin
      cyc_q <= 1'b0;
    end
  end

  // Command context: latched on the last header byte, advanced per completed word.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      words_left_q <= '0;
      any_err_q    <= 1'b0;
    end else if (state_q == ST_HDR2 && rx_fire) begin
      is_write_q   <= hdr[HDR_W_BIT];
      addr_q       <= hdr_addr;
      words_left_q <= burst_words(hdr[HDR_B_BIT], burst_size_i);
      any_err_q    <= 1'b0;
    end else if (word_done) begin
      addr_q       <= addr_q + ADDR_W'(4);
      words_left_q <= words_left_q - 4'd1;
      if (word_err) any_err_q <= 1'b1;
    end
  end

  // Sticky error flag; a new error outranks a clear in the same cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)     err_o <= 1'b0;
    else if (word_err)  err_o <= 1'b1;
    else if (err_clr_i) err_o <= 1'b0;
  end

  // Response byte: status in STAT, current read byte in RDTX, quiet otherwise.
  always_comb begin
    tx_dat_o = 8'h00;
    if (state_q == ST_STAT)      tx_dat_o = any_err_q ? STAT_ERR : STAT_OK;
    else if (state_q == ST_RDTX) tx_dat_o = bw_byte;
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = cyc_q & is_write_q;
  assign wb_adr_o = addr_q;
  assign wb_dat_o = wb_we_o ? bw_word : 32'h0;
  assign wb_sel_o = 4'hF;
  assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_boardman_wb_master.sv
// Self-checking bench for boardman_wb_master: directed scenarios plus
// randomized commands against a transaction-level reference model.
`timescale 1ns/1ps
module tb_boardman_wb_master;

  localparam int ADDR_W = 25;
  localparam int R_ACK  = 0;
  localparam int R_ERR  = 1;
  localparam int R_RTY  = 2;
  localparam int R_BOTH = 3;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_ni;
  logic [7:0]        rx_dat_i;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic [7:0]        tx_dat_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic [1:0]        burst_size_i;
  logic [3:0]        upper_addr_i;
  logic              wb_cyc_o, wb_stb_o, wb_we_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [31:0]       wb_dat_o;
  logic [3:0]        wb_sel_o;
  logic [31:0]       wb_dat_i;
  logic              wb_ack_i, wb_err_i, wb_rty_i;
  logic              busy_o, err_o, err_clr_i;

  boardman_wb_master dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_ni    (wb_rst_ni),
    .rx_dat_i     (rx_dat_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .tx_dat_o     (tx_dat_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .burst_size_i (burst_size_i),
    .upper_addr_i (upper_addr_i),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_sel_o     (wb_sel_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i),
    .wb_rty_i     (wb_rty_i),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .err_clr_i    (err_clr_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-word response plan, write data, and observed traffic.
  int                pkind [8];
  logic [31:0]       pdat  [8];
  logic [31:0]       wdat  [8];
  int                resp_kind_q [$];
  logic [31:0]       resp_dat_q  [$];
  logic [ADDR_W-1:0] obs_adr_q   [$];
  logic              obs_we_q    [$];
  logic [31:0]       obs_wdat_q  [$];
  logic [7:0]        obs_tx_q    [$];
  bit                slave_en = 1'b1;
  int                tx_mode  = 0;   // 0 random ready, 1 always ready, 2 stalled

  // WB target: responds after 0..3 cycles following the planned kind.
  initial begin : wb_slave
    int wait_cnt;
    int kind;
    wait_cnt = 0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = 32'h0;
    forever begin
      @(negedge wb_clk_i);
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (slave_en && wb_cyc_o && wb_stb_o) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          kind     = (resp_kind_q.size() > 0) ? resp_kind_q.pop_front() : R_ACK;
          wb_dat_i = (resp_dat_q.size() > 0) ? resp_dat_q.pop_front() : 32'h0;
          obs_adr_q.push_back(wb_adr_o);
          obs_we_q.push_back(wb_we_o);
          obs_wdat_q.push_back(wb_dat_o);
          case (kind)
            R_ERR:   wb_err_i = 1'b1;
            R_RTY:   wb_rty_i = 1'b1;
            R_BOTH:  begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
            default: wb_ack_i = 1'b1;
          endcase
          wait_cnt = $urandom_range(0, 3);
        end
      end
    end
  end

  // TX sink with optional backpressure; records accepted bytes.
  initial begin : tx_sink
    tx_ready_i = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      case (tx_mode)
        0:       tx_ready_i = ($urandom_range(0, 3) != 0);
        1:       tx_ready_i = 1'b1;
        default: tx_ready_i = 1'b0;
      endcase
      if (tx_valid_o && tx_ready_i) obs_tx_q.push_back(tx_dat_o);
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge wb_clk_i);
    rx_dat_i   = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && n < 5000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("rx_ready_o", rx_ready_o, 1);
    @(posedge wb_clk_i);
    #1 rx_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 20000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("busy_o_idle", busy_o, 0);
  endtask

  task automatic clear_obs();
    obs_adr_q.delete(); obs_we_q.delete(); obs_wdat_q.delete(); obs_tx_q.delete();
    resp_kind_q.delete(); resp_dat_q.delete();
  endtask

  // Issue one command and compare WB traffic, response bytes and err_o with the model.
  task automatic run_cmd(input bit w, input bit b, input bit u, input logic [20:0] a,
                         input logic [1:0] bs, input logic [3:0] ua);
    logic [23:0]       hdr;
    logic [ADDR_W-1:0] base, ea;
    logic [31:0]       word;
    logic [7:0]        exp_tx [$];
    int                n;
    bit                exp_err;
    n    = b ? (1 << bs) : 1;
    hdr  = {w, b, u, a};
    base = {(u ? ua : 4'h0), a};
    base[1:0] = 2'b00;
    exp_err = 1'b0;
    clear_obs();
    for (int i = 0; i < n; i++) begin
      if (pkind[i] != R_ACK) exp_err = 1'b1;
      resp_kind_q.push_back(pkind[i]);
      resp_dat_q.push_back(pdat[i]);
    end
    burst_size_i = bs;
    upper_addr_i = ua;
    @(negedge wb_clk_i) err_clr_i = 1'b1;
    @(negedge wb_clk_i) err_clr_i = 1'b0;
    send_byte(hdr[23:16]);
    send_byte(hdr[15:8]);
    send_byte(hdr[7:0]);
    // The command in flight must ignore these from now on.
    burst_size_i = 2'($urandom);
    upper_addr_i = 4'($urandom);
    if (w) begin
      for (int i = 0; i < n; i++) begin
        word = wdat[i];
        for (int j = 0; j < 4; j++) send_byte(word[31-8*j -: 8]);
      end
    end
    wait_idle();
    if (w) begin
      exp_tx.push_back(exp_err ? 8'h01 : 8'h00);
    end else begin
      for (int i = 0; i < n; i++) begin
        word = (pkind[i] == R_ACK) ? pdat[i] : 32'hFFFF_FFFF;
        for (int j = 0; j < 4; j++) exp_tx.push_back(word[31-8*j -: 8]);
      end
    end
    check("wb_words", obs_adr_q.size(), n);
    for (int i = 0; i < n && i < obs_adr_q.size(); i++) begin
      ea = base + ADDR_W'(4 * i);
      check($sformatf("wb_adr[%0d]", i), obs_adr_q[i], ea);
      check($sformatf("wb_we[%0d]", i), obs_we_q[i], w);
      if (w) check($sformatf("wb_dat[%0d]", i), obs_wdat_q[i], wdat[i]);
    end
    check("tx_count", obs_tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < obs_tx_q.size(); i++)
      check($sformatf("tx[%0d]", i), obs_tx_q[i], exp_tx[i]);
    check("err_o", err_o, exp_err);
  endtask

  initial begin : main
    logic [7:0] d0;
    int n, bad_dat, bad_wb, r;
    wb_rst_ni    = 1'b0;
    rx_dat_i     = 8'h00;
    rx_valid_i   = 1'b0;
    burst_size_i = 2'd0;
    upper_addr_i = 4'h0;
    err_clr_i    = 1'b0;
    for (int i = 0; i < 8; i++) begin pkind[i] = R_ACK; pdat[i] = 32'h0; wdat[i] = 32'h0; end

    // Reset state.
    repeat (3) @(negedge wb_clk_i);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_sel", wb_sel_o, 4'hF);
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_tx_dat", tx_dat_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    @(negedge wb_clk_i) wb_rst_ni = 1'b1;

    // Single read of 0x00C returning 3.
    pkind[0] = R_ACK; pdat[0] = 32'h0000_0003;
    run_cmd(1'b0, 1'b0, 1'b0, 21'h00000C, 2'd0, 4'h0);

    // Single write of 0x5A to 0x014.
    wdat[0] = 32'h0000_005A;
    run_cmd(1'b1, 1'b0, 1'b0, 21'h000014, 2'd0, 4'h0);

    // Read burst of 4 with upper bits 3; burst_size_i changes after the header.
    for (int i = 0; i < 4; i++) begin pkind[i] = R_ACK; pdat[i] = $urandom; end
    run_cmd(1'b0, 1'b1, 1'b1, 21'h000040, 2'd2, 4'h3);

    // Write burst of 2 with an error on word 1, then clear err_o.
    pkind[0] = R_ACK; pkind[1] = R_ERR; wdat[0] = $urandom; wdat[1] = $urandom;
    run_cmd(1'b1, 1'b1, 1'b0, 21'h000100, 2'd1, 4'h0);
    @(negedge wb_clk_i) err_clr_i = 1'b1;
    @(negedge wb_clk_i) err_clr_i = 1'b0;
    check("err_clr", err_o, 0);

    // Address wrap at the top of the 25-bit space, read burst of 8 with mixed errors.
    for (int i = 0; i < 8; i++) begin pkind[i] = (i % 3 == 1) ? R_BOTH : R_ACK; pdat[i] = $urandom; end
    pkind[5] = R_RTY;
    run_cmd(1'b0, 1'b1, 1'b1, 21'h1FFFF8, 2'd3, 4'hF);

    // TX backpressure during RDTX: byte held, WB idle.
    clear_obs();
    resp_kind_q.push_back(R_ACK);
    resp_dat_q.push_back(32'hA1B2_C3D4);
    tx_mode = 2;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    n = 0;
    while (!tx_valid_o && n < 1000) begin @(negedge wb_clk_i); n++; end
    check("stall_tx_valid", tx_valid_o, 1);
    d0 = tx_dat_o;
    bad_dat = 0; bad_wb = 0;
    repeat (20) begin
      @(negedge wb_clk_i);
      if (tx_dat_o !== d0 || !tx_valid_o) bad_dat++;
      if (wb_cyc_o || wb_stb_o) bad_wb++;
    end
    check("stall_first_byte", d0, 8'hA1);
    check("stall_dat_stable", bad_dat, 0);
    check("stall_wb_idle", bad_wb, 0);
    check("stall_no_tx", obs_tx_q.size(), 0);
    tx_mode = 1;
    wait_idle();
    check("stall_tx_count", obs_tx_q.size(), 4);
    if (obs_tx_q.size() == 4) begin
      check("stall_tx1", obs_tx_q[1], 8'hB2);
      check("stall_tx3", obs_tx_q[3], 8'hD4);
    end
    tx_mode = 0;

    // Reset in the middle of a WB cycle.
    clear_obs();
    slave_en = 1'b0;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h24);
    n = 0;
    while (!wb_cyc_o && n < 100) begin @(negedge wb_clk_i); n++; end
    check("pre_rst_cyc", wb_cyc_o, 1);
    #2 wb_rst_ni = 1'b0;
    #1;
    check("mid_rst_cyc", wb_cyc_o, 0);
    check("mid_rst_stb", wb_stb_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_rx_ready", rx_ready_o, 1);
    @(negedge wb_clk_i) wb_rst_ni = 1'b1;
    slave_en = 1'b1;
    repeat (5) @(negedge wb_clk_i);
    check("post_rst_tx_valid", tx_valid_o, 0);
    check("post_rst_no_tx", obs_tx_q.size(), 0);
    check("post_rst_rx_ready", rx_ready_o, 1);

`ifdef BOARDMAN_WB_TIMEOUT_EN
    // Unanswered read times out after 255 cycles of cyc.
    clear_obs();
    slave_en = 1'b0;
    tx_mode  = 1;
    @(negedge wb_clk_i) err_clr_i = 1'b1;
    @(negedge wb_clk_i) err_clr_i = 1'b0;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h50);
    n = 0;
    while (!wb_cyc_o && n < 100) begin @(negedge wb_clk_i); n++; end
    n = 0;
    while (wb_cyc_o && n < 1000) begin n++; @(negedge wb_clk_i); end
    check("tmo_cyc_cycles", n, 255);
    wait_idle();
    check("tmo_tx_count", obs_tx_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_tx_q.size(); i++)
      check($sformatf("tmo_tx[%0d]", i), obs_tx_q[i], 8'hFF);
    check("tmo_err", err_o, 1);
    slave_en = 1'b1;
    tx_mode  = 0;
`endif

    // Randomized commands.
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 7);
        pkind[i] = (r < 5) ? R_ACK : (r == 5) ? R_ERR : (r == 6) ? R_RTY : R_BOTH;
        pdat[i]  = $urandom;
        wdat[i]  = $urandom;
      end
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              21'($urandom), 2'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
